// File: rtl/core_pkg.sv
// Shared core-wide constants and types for the fetch stage.
// Module parameters default to these values so that a single edit retargets the core.
package core_pkg;

    localparam int unsigned CORE_XLEN      = 32;
    localparam logic [31:0] CORE_RESET_VEC = 32'h0000_0000;
    localparam int unsigned CORE_PC_INC    = 4;
    localparam logic [31:0] CORE_NOP_INST  = 32'h0000_0013;

    // What the fetch state does on the coming edge, already priority-resolved.
    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2,
        ACT_RESET    = 2'd3
    } fetch_act_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry hold buffer for the IF/ID view.
// It captures memory read data on the first stalled edge and keeps it until the stall ends.
module fetch_hold_buf
    import core_pkg::*;
#(
    parameter int unsigned XLEN = CORE_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_capture,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_inst_cur
);

    logic            hold_vld_q;
    logic [XLEN-1:0] hold_inst_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_vld_q  <= 1'b0;
            hold_inst_q <= '0;
        end else if (i_clear) begin
            hold_vld_q  <= 1'b0;
        end else if (i_capture && !hold_vld_q) begin
            // Memory output is only trustworthy on the first stalled cycle.
            hold_vld_q  <= 1'b1;
            hold_inst_q <= i_rdata;
        end
    end

    assign o_inst_cur = hold_vld_q ? hold_inst_q : i_rdata;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle synchronous imem,
// and presents {pc, inc_pc, inst, valid} to decode with stall hold and redirect flush.
module fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned     XLEN      = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(CORE_RESET_VEC),
    parameter int unsigned     PC_INC    = CORE_PC_INC,
    parameter logic [XLEN-1:0] NOP_INST  = XLEN'(CORE_NOP_INST)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_imem_addr,
    output logic            o_imem_en,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_inc_pc,
    output logic [XLEN-1:0] o_inst,
    output logic            o_valid,
    output logic            o_misalign_err
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic            rsp_vld_q;
    logic            err_q;
    logic [XLEN-1:0] inst_cur;
    fetch_act_e      act;

    always_comb begin
        act = ACT_ADVANCE;
        if (i_rst) begin
            act = ACT_RESET;
        end else if (i_redirect) begin
            act = ACT_REDIRECT;
        end else if (i_stall) begin
            act = ACT_STALL;
        end
    end

    always_ff @(posedge i_clk) begin
        case (act)
            ACT_RESET: begin
                pc_q      <= RESET_VEC;
                rsp_pc_q  <= RESET_VEC;
                rsp_vld_q <= 1'b0;
                err_q     <= 1'b0;
            end
            ACT_REDIRECT: begin
                // Low bits are dropped so fetch stays word aligned; the error is latched.
                pc_q      <= {i_redirect_pc[XLEN-1:2], 2'b00};
                rsp_vld_q <= 1'b0;
                err_q     <= err_q | (|i_redirect_pc[1:0]);
            end
            ACT_STALL: begin
            end
            default: begin
                rsp_pc_q  <= pc_q;
                rsp_vld_q <= 1'b1;
                pc_q      <= pc_q + XLEN'(PC_INC);
            end
        endcase
    end

    fetch_hold_buf #(
        .XLEN(XLEN)
    ) u_hold_buf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_capture  (act == ACT_STALL),
        .i_clear    ((act == ACT_ADVANCE) || (act == ACT_REDIRECT)),
        .i_rdata    (i_imem_rdata),
        .o_inst_cur (inst_cur)
    );

    assign o_imem_addr    = pc_q;
    assign o_imem_en      = ~i_stall | i_redirect;
    assign o_pc           = rsp_pc_q;
    assign o_inc_pc       = rsp_pc_q + XLEN'(PC_INC);
    assign o_valid        = rsp_vld_q;
    assign o_inst         = rsp_vld_q ? inst_cur : NOP_INST;
    assign o_misalign_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected IF/ID entries are queued by the stimulus
// and consumed by a monitor whenever decode accepts (o_valid and no stall).
`timescale 1ns/1ps
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] o_pc;
    logic [31:0] o_inc_pc;
    logic [31:0] o_inst;
    logic        o_valid;
    logic        o_err;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_unit dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall        (stall),
        .i_redirect     (redir),
        .i_redirect_pc  (redir_pc),
        .o_imem_addr    (imem_addr),
        .o_imem_en      (imem_en),
        .i_imem_rdata   (imem_rdata),
        .o_pc           (o_pc),
        .o_inc_pc       (o_inc_pc),
        .o_inst         (o_inst),
        .o_valid        (o_valid),
        .o_misalign_err (o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mi(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous imem; a disabled read leaves toggling garbage on the bus.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mi(imem_addr);
        else         imem_rdata <= ~imem_rdata;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inc  = pc + 32'd4;
        e.inst = mi(pc);
        exp_q.push_back(e);
    endtask

    // Drive one cycle's inputs just after the edge, then wait to mid-cycle.
    task automatic cyc(input logic s, input logic r, input logic [31:0] rpc, input logic rs);
        @(posedge clk);
        #1;
        stall    = s;
        redir    = r;
        redir_pc = rpc;
        rst      = rs;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid && !stall) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_empty: got pc %h with no expected entry", o_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_pc", o_pc, e.pc);
                chk("sb_inc_pc", o_inc_pc, e.inc);
                chk("sb_inst", o_inst, e.inst);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        stall    = 1'b0;
        redir    = 1'b0;
        redir_pc = 32'h0;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_inst", o_inst, 32'h0000_0013);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_err", {31'd0, o_err}, 32'd0);

        // Sequential fetch, then a 3-cycle stall at pc 8.
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        cyc(0, 0, 0, 0);
        chk("first_bubble", {31'd0, o_valid}, 32'd0);
        chk("first_en", {31'd0, imem_en}, 32'd1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0);
            chk("stall_en", {31'd0, imem_en}, 32'd0);
            chk("stall_pc", o_pc, 32'h8);
            chk("stall_inst", o_inst, mi(32'h8));
        end
        cyc(0, 0, 0, 0);
        chk("release_inst", o_inst, mi(32'h8));

        // Redirect to 0x100 while pc 12 is presented.
        push(32'h100);
        cyc(0, 1, 32'h100, 0);
        cyc(0, 0, 0, 0);
        chk("redir_bubble", {31'd0, o_valid}, 32'd0);
        chk("redir_nop", o_inst, 32'h0000_0013);
        chk("redir_addr", imem_addr, 32'h100);
        cyc(0, 0, 0, 0);

        // Redirect with concurrent stall: redirect wins.
        push(32'h200); push(32'h204);
        cyc(1, 1, 32'h200, 0);
        chk("rs_en", {31'd0, imem_en}, 32'd1);
        cyc(0, 0, 0, 0);
        chk("rs_bubble", {31'd0, o_valid}, 32'd0);
        chk("rs_addr", imem_addr, 32'h200);
        cyc(0, 0, 0, 0);
        chk("err_clear", {31'd0, o_err}, 32'd0);

        // Misaligned redirect target.
        push(32'h100); push(32'h104); push(32'h108);
        cyc(0, 1, 32'h103, 0);
        cyc(0, 0, 0, 0);
        chk("mis_bubble", {31'd0, o_valid}, 32'd0);
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_err", {31'd0, o_err}, 32'd1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("mis_sticky", {31'd0, o_err}, 32'd1);

        // Reset while the hold buffer is full.
        cyc(1, 0, 0, 0);
        chk("hold_pc", o_pc, 32'h10C);
        cyc(1, 0, 0, 1);
        chk("hold_inst", o_inst, mi(32'h10C));
        push(32'h0); push(32'h4);
        cyc(0, 0, 0, 0);
        chk("rst2_valid", {31'd0, o_valid}, 32'd0);
        chk("rst2_inst", o_inst, 32'h0000_0013);
        chk("rst2_pc", o_pc, 32'h0);
        chk("rst2_addr", imem_addr, 32'h0);
        chk("rst2_err", {31'd0, o_err}, 32'd0);
        cyc(0, 0, 0, 0);

        // PC wrap at the top of the address space.
        push(32'hFFFF_FFFC); push(32'h0);
        cyc(0, 1, 32'hFFFF_FFFC, 0);
        cyc(0, 0, 0, 0);
        chk("wrap_bubble", {31'd0, o_valid}, 32'd0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h4);
        cyc(1, 0, 0, 0);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
